// File: rtl/vga_pkg.sv
// ============================================================================
// vga_pkg : shared types, constants and default-palette expansion for the
//           VGA pixel compositor.                             Revision: 1.0
// ============================================================================
`default_nettype none

package vga_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int         H_ACTIVE       = 640;
  localparam int         V_ACTIVE       = 480;
  localparam int         PAL_AW         = 8;
  localparam logic [7:0] TRANSP_IDX_DEF = 8'h00;

  // RRRGGGBB index expanded to 4 bits per channel by replicating the MSBs.
  function automatic rgb12 default_pal(input logic [7:0] idx);
    rgb12 c;
    c.r = {idx[7:5], idx[7]};
    c.g = {idx[4:2], idx[4]};
    c.b = {idx[1:0], idx[1:0]};
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_pixel_compositor_if.sv
// ============================================================================
// vga_pixel_compositor_if : sprite/sync inputs, palette write port and pin
//                           outputs of the pixel compositor.  Revision: 1.0
// ============================================================================
`default_nettype none

interface vga_pixel_compositor_if;
  logic        i_hs;
  logic        i_vs;
  logic        i_active;
  logic [1:0]  i_spr_on;
  logic [7:0]  i_spr_data;
  logic [11:0] i_bg_rgb;
  logic        i_pal_we;
  logic [7:0]  i_pal_addr;
  logic [11:0] i_pal_wdata;
  logic        o_pal_ack;
  logic        o_init_busy;
  logic [3:0]  o_red;
  logic [3:0]  o_green;
  logic [3:0]  o_blue;
  logic        o_hs;
  logic        o_vs;

  modport master (
    output i_hs, i_vs, i_active, i_spr_on, i_spr_data, i_bg_rgb,
           i_pal_we, i_pal_addr, i_pal_wdata,
    input  o_pal_ack, o_init_busy, o_red, o_green, o_blue, o_hs, o_vs
  );

  modport slave (
    input  i_hs, i_vs, i_active, i_spr_on, i_spr_data, i_bg_rgb,
           i_pal_we, i_pal_addr, i_pal_wdata,
    output o_pal_ack, o_init_busy, o_red, o_green, o_blue, o_hs, o_vs
  );
endinterface

`default_nettype wire

// File: rtl/palette_ram.sv
// ============================================================================
// palette_ram : DEPTH x DW palette, one synchronous write port and one
//               registered read-first read port.             Revision: 1.0
// ============================================================================
`default_nettype none

module palette_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Read samples the array before this edge's write lands: read-first.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/vga_pixel_compositor.sv
// ============================================================================
// vga_pixel_compositor : palette lookup, background fallback and sync
//                        re-timing for the Basys 3 VGA pins.  Revision: 1.0
// ============================================================================
`default_nettype none

module vga_pixel_compositor
  import vga_pkg::*;
#(
  parameter int         DATA_LAT   = 2,
  parameter int         ON_LAT     = 1,
  parameter logic [7:0] TRANSP_IDX = TRANSP_IDX_DEF,
  parameter int         PAL_DEPTH  = 256
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  vga_pixel_compositor_if.slave   bus
);

  localparam int ON_DLY = DATA_LAT - ON_LAT;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PAL_AW-1:0] r_cnt;
  logic [PAL_AW-1:0] w_cnt_nxt;
  logic              r_ack;
  logic              w_ram_we;
  logic [PAL_AW-1:0] w_ram_addr;
  rgb12              w_ram_wdata;
  rgb12              w_ram_rdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= (r_state == ST_RUN) && bus.i_pal_we;
    end
  end

  // INIT owns the write port; external writes only reach the RAM in RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ram_we    = 1'b0;
    w_ram_addr  = bus.i_pal_addr;
    w_ram_wdata = bus.i_pal_wdata;
    case (r_state)
      ST_INIT: begin
        w_ram_we    = 1'b1;
        w_ram_addr  = r_cnt;
        w_ram_wdata = default_pal(r_cnt);
        w_cnt_nxt   = r_cnt + 1'b1;
        if (r_cnt == '1) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_ram_we = bus.i_pal_we;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  palette_ram #(
    .DEPTH (PAL_DEPTH),
    .AW    (PAL_AW),
    .DW    (12)
  ) u_palette_ram (
    .clk   (i_clk),
    .we    (w_ram_we),
    .waddr (w_ram_addr),
    .wdata (w_ram_wdata),
    .raddr (bus.i_spr_data),
    .rdata (w_ram_rdata)
  );

  logic                     w_on_in;
  logic                     w_on_s0;
  logic [DATA_LAT-1:0][2:0] r_sync_dly;
  logic [DATA_LAT:0][2:0]   w_sync_cat;
  logic                     w_hs_s0;
  logic                     w_vs_s0;
  logic                     w_act_s0;

  assign w_on_in = |bus.i_spr_on;

  generate
    if (ON_DLY > 0) begin : g_on_dly
      logic [ON_DLY-1:0] r_on_dly;
      logic [ON_DLY:0]   w_on_cat;
      assign w_on_cat = {r_on_dly, w_on_in};
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_on_dly <= '0;
        end else begin
          r_on_dly <= w_on_cat[ON_DLY-1:0];
        end
      end
      assign w_on_s0 = r_on_dly[ON_DLY-1];
    end else begin : g_on_pass
      assign w_on_s0 = w_on_in;
    end
  endgenerate

  assign w_sync_cat = {r_sync_dly, bus.i_hs, bus.i_vs, bus.i_active};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync_dly <= '0;
    end else begin
      r_sync_dly <= w_sync_cat[DATA_LAT-1:0];
    end
  end

  assign {w_hs_s0, w_vs_s0, w_act_s0} = r_sync_dly[DATA_LAT-1];

  logic       r_s1_hs;
  logic       r_s1_vs;
  logic       r_s1_act;
  logic       r_s1_on;
  logic [7:0] r_s1_idx;
  rgb12       w_rgb;
  rgb12       r_rgb;
  logic       r_hs;
  logic       r_vs;

  // S1 runs in parallel with the registered palette read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_hs  <= 1'b0;
      r_s1_vs  <= 1'b0;
      r_s1_act <= 1'b0;
      r_s1_on  <= 1'b0;
      r_s1_idx <= '0;
    end else begin
      r_s1_hs  <= w_hs_s0;
      r_s1_vs  <= w_vs_s0;
      r_s1_act <= w_act_s0;
      r_s1_on  <= w_on_s0;
      r_s1_idx <= bus.i_spr_data;
    end
  end

  always_comb begin
    w_rgb = '0;
    if ((r_state == ST_RUN) && r_s1_act) begin
      if (!r_s1_on || (r_s1_idx == TRANSP_IDX)) begin
        w_rgb = bus.i_bg_rgb;
      end else begin
        w_rgb = w_ram_rdata;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rgb <= '0;
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
    end else begin
      r_rgb <= w_rgb;
      r_hs  <= r_s1_hs;
      r_vs  <= r_s1_vs;
    end
  end

  assign bus.o_red       = r_rgb.r;
  assign bus.o_green     = r_rgb.g;
  assign bus.o_blue      = r_rgb.b;
  assign bus.o_hs        = r_hs;
  assign bus.o_vs        = r_vs;
  assign bus.o_pal_ack   = r_ack;
  assign bus.o_init_busy = (r_state == ST_INIT);

endmodule

`default_nettype wire

// File: tb/tb_vga_pixel_compositor.sv
// ============================================================================
// tb_vga_pixel_compositor : directed-vector bench for vga_pixel_compositor.
//                                                              Revision: 1.0
// ============================================================================
`default_nettype none

module tb_vga_pixel_compositor;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  vga_pixel_compositor_if bus();

  vga_pixel_compositor #(
    .DATA_LAT   (2),
    .ON_LAT     (1),
    .TRANSP_IDX (8'h00),
    .PAL_DEPTH  (256)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [11:0] rgb_o;
  assign rgb_o = {bus.o_red, bus.o_green, bus.o_blue};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.i_hs        = 1'b0;
    bus.i_vs        = 1'b0;
    bus.i_active    = 1'b0;
    bus.i_spr_on    = 2'd0;
    bus.i_spr_data  = 8'h00;
    bus.i_pal_we    = 1'b0;
    bus.i_pal_addr  = 8'h00;
    bus.i_pal_wdata = 12'h000;
  endtask

  // Counts busy cycles from reset release; optional probes exercise INIT.
  task automatic init_phase(input bit probe, input string tag);
    int s;
    s = 0;
    while (bus.o_init_busy && s < 400) begin
      if (probe) begin
        case (s)
          9: begin
            bus.i_pal_we    = 1'b1;
            bus.i_pal_addr  = 8'h05;
            bus.i_pal_wdata = 12'h555;
          end
          10: begin
            bus.i_pal_we = 1'b0;
            check("init_no_ack", bus.o_pal_ack, 1'b0);
          end
          20: begin
            bus.i_hs       = 1'b1;
            bus.i_vs       = 1'b1;
            bus.i_active   = 1'b1;
            bus.i_spr_on   = 2'd1;
            bus.i_spr_data = 8'hE0;
          end
          23: check("init_hs_t3", bus.o_hs, 1'b0);
          24: begin
            check("init_hs_t4", bus.o_hs, 1'b1);
            check("init_vs_t4", bus.o_vs, 1'b1);
            check("init_rgb_zero", rgb_o, 12'h000);
          end
          30: clear_inputs();
          default: ;
        endcase
      end
      s++;
      tick();
    end
    check(tag, s, 256);
  endtask

  // One isolated pixel driven at the documented input latencies; optional
  // same-cycle palette write to the address being read.
  task automatic pixel(input logic act, input logic [1:0] on, input logic [7:0] idx,
                       input logic cwe, input logic [11:0] cdata,
                       input logic [11:0] exp, input string tag);
    bus.i_hs     = 1'b1;
    bus.i_vs     = 1'b1;
    bus.i_active = act;
    tick();
    bus.i_hs     = 1'b0;
    bus.i_vs     = 1'b0;
    bus.i_active = 1'b0;
    bus.i_spr_on = on;
    tick();
    bus.i_spr_on    = 2'd0;
    bus.i_spr_data  = idx;
    bus.i_pal_we    = cwe;
    bus.i_pal_addr  = idx;
    bus.i_pal_wdata = cdata;
    tick();
    bus.i_spr_data = 8'h00;
    bus.i_pal_we   = 1'b0;
    check({tag, "_hs_t3"}, bus.o_hs, 1'b0);
    tick();
    check({tag, "_rgb"}, rgb_o, exp);
    check({tag, "_hs_t4"}, bus.o_hs, 1'b1);
    check({tag, "_vs_t4"}, bus.o_vs, 1'b1);
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    bus.i_bg_rgb = 12'h123;
    #3;
    check("rst_rgb", rgb_o, 12'h000);
    check("rst_hs", bus.o_hs, 1'b0);
    check("rst_vs", bus.o_vs, 1'b0);
    check("rst_ack", bus.o_pal_ack, 1'b0);
    check("rst_busy", bus.o_init_busy, 1'b1);
    tick();
    tick();
    rst_n = 1'b1;
    init_phase(1'b1, "init_len");

    pixel(1'b1, 2'd1, 8'hE0, 1'b0, 12'h000, 12'hF00, "pix_e0");
    pixel(1'b1, 2'd1, 8'h05, 1'b0, 12'h000, 12'h025, "init_wr_ignored");

    bus.i_pal_we    = 1'b1;
    bus.i_pal_addr  = 8'h05;
    bus.i_pal_wdata = 12'h0A5;
    check("ack_before", bus.o_pal_ack, 1'b0);
    tick();
    bus.i_pal_we = 1'b0;
    check("ack", bus.o_pal_ack, 1'b1);
    tick();
    check("ack_pulse", bus.o_pal_ack, 1'b0);
    tick();

    pixel(1'b1, 2'd1, 8'h05, 1'b0, 12'h000, 12'h0A5, "wr05");
    pixel(1'b1, 2'd0, 8'h05, 1'b0, 12'h000, 12'h123, "spr_off");
    pixel(1'b1, 2'd1, 8'h00, 1'b0, 12'h000, 12'h123, "transp");
    pixel(1'b0, 2'd1, 8'hE0, 1'b0, 12'h000, 12'h000, "inactive");
    pixel(1'b1, 2'd2, 8'hE0, 1'b0, 12'h000, 12'hF00, "on_two");

    bus.i_pal_we    = 1'b1;
    bus.i_pal_addr  = 8'h10;
    bus.i_pal_wdata = 12'h111;
    tick();
    bus.i_pal_addr  = 8'h11;
    bus.i_pal_wdata = 12'h222;
    check("b2b_ack0", bus.o_pal_ack, 1'b1);
    tick();
    bus.i_pal_we = 1'b0;
    check("b2b_ack1", bus.o_pal_ack, 1'b1);
    tick();
    check("b2b_ack_end", bus.o_pal_ack, 1'b0);
    tick();
    pixel(1'b1, 2'd1, 8'h10, 1'b0, 12'h000, 12'h111, "b2b_10");
    pixel(1'b1, 2'd1, 8'h11, 1'b0, 12'h000, 12'h222, "b2b_11");

    pixel(1'b1, 2'd1, 8'h05, 1'b1, 12'h777, 12'h0A5, "collide_old");
    pixel(1'b1, 2'd1, 8'h05, 1'b0, 12'h000, 12'h777, "collide_new");

    bus.i_hs       = 1'b1;
    bus.i_vs       = 1'b1;
    bus.i_active   = 1'b1;
    bus.i_spr_on   = 2'd1;
    bus.i_spr_data = 8'hE0;
    repeat (6) tick();
    check("stream_rgb", rgb_o, 12'hF00);
    check("stream_hs", bus.o_hs, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rgb", rgb_o, 12'h000);
    check("async_hs", bus.o_hs, 1'b0);
    check("async_vs", bus.o_vs, 1'b0);
    check("async_busy", bus.o_init_busy, 1'b1);
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (100) tick();
    check("mid_init_busy", bus.o_init_busy, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    init_phase(1'b0, "reinit_len");
    pixel(1'b1, 2'd1, 8'h05, 1'b0, 12'h000, 12'h025, "reinit_05");
    pixel(1'b1, 2'd1, 8'h10, 1'b0, 12'h000, 12'h090, "reinit_10");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_pixel_compositor.md
Name: vga_pixel_compositor

Overview:
- Downstream of the sprite stage. Consumes each sprite's on-flag and 8-bit palette index, plus raw VGA sync/active from the sync generator.
- Looks up a 256 x 12-bit palette RAM, falls back to a background colour for transparent or off pixels, and drives the Basys 3 4-bit R/G/B and HS/VS pins.
- All signals are re-timed so that sync and colour leave the block aligned.
- Runs on the 100 MHz onboard clock.

Parameters:
- DATA_LAT, 2: cycles from sync-generator inputs (hs/vs/active) to arrival of sprite palette index.
- ON_LAT, 1: cycles from sync-generator inputs to arrival of sprite on-flag.
- TRANSP_IDX, 8'h00: palette index treated as transparent.
- PAL_DEPTH, 256: palette entries; address width 8.

Ports:
- i_clk  in  1  system clock, 100 MHz
- i_rst_n  in  1  async active-low reset
- i_hs  in  1  raw horizontal sync from sync generator
- i_vs  in  1  raw vertical sync
- i_active  in  1  raw active-video flag (the generator's aactive)
- i_spr_on  in  2  sprite on-flag; any nonzero value = on; arrives ON_LAT after i_active
- i_spr_data  in  8  sprite palette index; arrives DATA_LAT after i_active
- i_bg_rgb  in  12  background colour {R,G,B}; quasi-static
- i_pal_we  in  1  palette write request, single-cycle
- i_pal_addr  in  8  palette write address
- i_pal_wdata  in  12  palette write data {R,G,B}
- o_pal_ack  out  1  write accepted, one-cycle pulse
- o_init_busy  out  1  default-palette load in progress
- o_red  out  4
- o_green  out  4
- o_blue  out  4
- o_hs  out  1
- o_vs  out  1

Behaviour:
- Reset is asynchronous and active-low; single clock i_clk.
- Reset values: o_red/o_green/o_blue = 0, o_hs = 0, o_vs = 0, o_pal_ack = 0, o_init_busy = 1, FSM = INIT, init counter = 0, all delay-line stages = 0.
- FSM INIT:
  - Each cycle writes palette[cnt] = {cnt[7:5],cnt[7], cnt[4:2],cnt[4], cnt[1:0],cnt[1:0]}, then cnt++.
  - After writing entry 255, goes to RUN (256 cycles total). o_init_busy falls on the first RUN cycle.
  - External writes are ignored; o_pal_ack stays 0.
  - RGB outputs forced to 0. Syncs still propagate so the monitor keeps lock.
- FSM RUN:
  - i_pal_we writes i_pal_wdata to i_pal_addr; o_pal_ack = 1 on the next cycle.
  - Back-to-back writes are accepted every cycle.
- Alignment:
  - i_spr_on is delayed (DATA_LAT - ON_LAT) cycles to match i_spr_data.
  - hs/vs/active are delayed DATA_LAT cycles to match, forming stage S0.
- Pipeline:
  - S0: palette read at i_spr_data. Registered read, 1 cycle.
  - S1: on/active/hs/vs/index carried one stage.
  - S2: output register.
- Colour select at S2:
  - active = 0 -> RGB 0.
  - Otherwise sprite off or index == TRANSP_IDX -> i_bg_rgb.
  - Otherwise -> palette data.
- Latency: output appears DATA_LAT + 2 cycles after the corresponding i_hs/i_vs/i_active. It is identical for sync and colour.
- Read/write collision on the same address in one cycle: the read returns the old value (read-first); the new value is visible from the next read.
- Reset asserted mid-frame or mid-INIT: immediate clear, and INIT restarts from 0 after release. Palette RAM contents are not cleared by reset, only overwritten by INIT.
- Sync polarity is passed through unchanged; the block does not invert.

Decomposition:
- Shared package vga_pkg:
  - rgb12 typedef {r,g,b} of 4 bits each.
  - Constants H_ACTIVE = 640, V_ACTIVE = 480.
  - TRANSP_IDX default.
  - Default-palette expansion function.
- One natural sub-module: palette_ram (256x12, one synchronous write port, one synchronous read-first read port). The INIT FSM multiplexes onto its write port.
- Delay lines are implemented inline as shift registers.

Test Plan:
- Reset, then 256 cycles -> o_init_busy = 1 for exactly 256 cycles after i_rst_n rises. A write at cycle 10 of INIT gives no o_pal_ack and does not alter palette[addr].
- After INIT, i_active = 1 with i_spr_on = 1 and i_spr_data = 8'hE0 aligned per latencies -> RGB = 12'hF00 exactly 4 cycles after i_active.
- Write palette[0x05] = 12'h0A5 -> o_pal_ack pulse next cycle. A later pixel with index 0x05 and on = 1 -> RGB = 0A5.
- Sprite off, or index 0x00 with on = 1, and i_bg_rgb = 12'h123 -> RGB = 123. The same pixel with i_active = 0 -> RGB = 000.
- Toggle i_hs at cycle t -> o_hs toggles at t+4 in both INIT and RUN. Write and read of 0x05 in the same cycle returns the old value.
- Assert i_rst_n = 0 mid-frame -> all outputs 0 asynchronously. After release, o_init_busy = 1 and INIT restarts from entry 0.
